// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    DMEM_WAIT = 2'b01,
    HALTED    = 2'b10
  } state_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = ctrl_t'(8'b1111_1000);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(8'b0000_0000);

  // Bubble loaded by a flushed pipeline register: NOP, no register write, no memory access.
  localparam int unsigned INSN_W        = 32;
  localparam logic [INSN_W-1:0] BUBBLE_INSN = 32'h0000_0013;
  localparam logic BUBBLE_R_WE          = 1'b0;
  localparam logic BUBBLE_MEM_EN        = 1'b0;

  // Control when no memory stall is pending: branch beats load-use beats halt.
  function automatic ctrl_t run_ctrl(input logic branch_taken, input logic load_use,
                                     input logic halt_req);
    ctrl_t c;
    c = CTRL_RUN;
    if (branch_taken) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_we       = 1'b0;
      c.ifid_we     = 1'b0;
      c.idex_we     = 1'b0;
      c.exmem_flush = 1'b1;
    end else if (halt_req) begin
      c = CTRL_FREEZE;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Parameterised-width saturating counter with synchronous clear and increment.
module sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/halt controller with DMEM wait timeout and stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_use,
  input  logic                   branch_taken,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  input  logic                   halt_req,
  input  logic                   resume,
  output logic                   pc_we,
  output logic                   ifid_we,
  output logic                   idex_we,
  output logic                   exmem_we,
  output logic                   memwb_we,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic                   halted,
  output logic                   bus_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = 8;

  state_e            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
  ctrl_t             ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // Mealy outputs and next state; reset forces the free-running defaults.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    ctrl        = CTRL_RUN;
    halted      = 1'b0;
    bus_err     = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            ctrl        = CTRL_FREEZE;
            state_nx    = DMEM_WAIT;
            wait_cnt_nx = WAIT_W'(1);
          end else begin
            ctrl     = run_ctrl(branch_taken, load_use, halt_req);
            state_nx = (!branch_taken && !load_use && halt_req) ? HALTED : RUN;
          end
        end
        DMEM_WAIT: begin
          if (!dmem_ready) begin
            ctrl = CTRL_FREEZE;
            if (wait_cnt == WAIT_W'(TIMEOUT)) begin
              bus_err  = 1'b1;
              state_nx = HALTED;
            end else begin
              wait_cnt_nx = wait_cnt + WAIT_W'(1);
            end
          end else begin
            ctrl     = run_ctrl(branch_taken, load_use, halt_req);
            state_nx = (!branch_taken && !load_use && halt_req) ? HALTED : RUN;
          end
        end
        HALTED: begin
          ctrl   = CTRL_FREEZE;
          halted = 1'b1;
          if (resume) state_nx = RUN;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  assign pc_we       = ctrl.pc_we;
  assign ifid_we     = ctrl.ifid_we;
  assign idex_we     = ctrl.idex_we;
  assign exmem_we    = ctrl.exmem_we;
  assign memwb_we    = ctrl.memwb_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;

  sat_cnt #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (!ctrl.pc_we),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed + randomized bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int TIMEOUT = 4;
  localparam int SCW     = 4;
  localparam int SAT_MAX = (1 << SCW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_use = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic halt_req = 1'b0, resume = 1'b0;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_flush, idex_flush, exmem_flush, halted, bus_err;
  logic [SCW-1:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0 = running, 1 = waiting on memory, 2 = halted.
  int m_mode  = 0;
  int m_wait  = 0;
  int m_stall = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req), .resume(resume),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .memwb_we(memwb_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .halted(halted), .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // One clock: drive at negedge, compare just after, advance model at posedge.
  task automatic cycle(input bit r, input bit lu, input bit br, input bit rq,
                       input bit rd, input bit hr, input bit rs, input string tag);
    logic [9:0] exp;  // {pc,ifid,idex,exmem,memwb we, ifid,idex,exmem flush, halted, bus_err}
    int nmode, nwait, nstall;
    bit stall_mem;
    @(negedge clk);
    rst = r; load_use = lu; branch_taken = br; dmem_req = rq; dmem_ready = rd;
    halt_req = hr; resume = rs;
    #1;
    nmode = m_mode; nwait = m_wait;
    exp = 10'b11111_000_00;
    if (r) begin
      nmode = 0; nwait = 0;
    end else if (m_mode == 2) begin
      exp = 10'b00000_000_10;
      if (rs) nmode = 0;
    end else begin
      stall_mem = (m_mode == 0) ? (rq && !rd) : !rd;
      if (stall_mem) begin
        exp = 10'b0;
        if (m_mode == 0) begin
          nmode = 1; nwait = 1;
        end else if (m_wait == TIMEOUT) begin
          exp[0] = 1'b1; nmode = 2;
        end else begin
          nwait = m_wait + 1;
        end
      end else begin
        nmode = 0;
        if (br)      exp = 10'b11111_110_00;
        else if (lu) exp = 10'b00011_001_00;
        else if (hr) begin exp = 10'b0; nmode = 2; end
      end
    end
    check({tag, ":ctrl"},
          32'({pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush, exmem_flush, halted, bus_err}), 32'(exp));
    check({tag, ":stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    if (r) nstall = 0;
    else if (!exp[9]) nstall = (m_stall >= SAT_MAX) ? SAT_MAX : m_stall + 1;
    else nstall = m_stall;
    @(posedge clk);
    m_mode = nmode; m_wait = nwait; m_stall = nstall;
  endtask

  task automatic idle(input string tag);
    cycle(0, 0, 0, 0, 1, 0, 0, tag);
  endtask

  task automatic do_reset();
    cycle(1, 1, 1, 1, 0, 1, 1, "reset");
  endtask

  initial begin
    do_reset();
    do_reset();
    idle("post_reset");

    // Single load-use bubble.
    cycle(0, 1, 0, 0, 1, 0, 0, "load_use");
    idle("after_load_use");
    check("load_use_stall_cnt", 32'(stall_cnt), 32'd1);

    // Branch masks a simultaneous load-use; resume outside halt is ignored.
    cycle(0, 1, 1, 0, 1, 0, 1, "branch_vs_lu");
    idle("after_branch");

    // Three frozen memory cycles, then advance.
    do_reset();
    cycle(0, 0, 0, 1, 0, 0, 0, "dmem_w1");
    cycle(0, 0, 0, 1, 0, 0, 0, "dmem_w2");
    cycle(0, 0, 0, 1, 0, 0, 0, "dmem_w3");
    cycle(0, 0, 0, 1, 1, 0, 0, "dmem_done");
    check("dmem_stall_cnt", 32'(stall_cnt), 32'd3);
    idle("after_dmem");

    // Memory timeout -> bus error -> halted -> resume.
    do_reset();
    cycle(0, 0, 0, 1, 0, 0, 0, "to_enter");
    for (int i = 0; i < TIMEOUT; i++) cycle(0, 0, 0, 1, 0, 0, 0, "to_wait");
    cycle(0, 0, 0, 0, 0, 1, 0, "to_halted");
    cycle(0, 0, 0, 0, 0, 1, 1, "to_resume");
    idle("to_run");

    // Reset in the middle of a memory wait.
    do_reset();
    cycle(0, 0, 0, 1, 0, 0, 0, "mid_enter");
    cycle(0, 0, 0, 1, 0, 0, 0, "mid_w1");
    cycle(1, 0, 0, 1, 0, 0, 0, "mid_rst");
    idle("mid_after");

    // Debug halt held long enough to saturate the stall counter.
    do_reset();
    cycle(0, 0, 0, 0, 1, 1, 0, "halt_enter");
    for (int i = 0; i < 19; i++) cycle(0, 1, 0, 1, 0, 1, 0, "halt_hold");
    check("stall_sat", 32'(stall_cnt), 32'(SAT_MAX));
    cycle(0, 0, 0, 0, 1, 0, 1, "halt_resume");
    idle("halt_run");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(63) == 0),
            ($urandom_range(3) == 0),
            ($urandom_range(3) == 0),
            ($urandom_range(2) == 0),
            ($urandom_range(3) != 0),
            ($urandom_range(7) == 0),
            ($urandom_range(5) == 0),
            "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum DMEM_WAIT cycles before a bus error (range 1..255).
REQ-002 SHALL have parameter STALL_CNT_W, default 16, meaning the width of the stall-cycle counter.
REQ-003 clk  in  1  clock; all state updates on the posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 load_use  in  1  load-use hazard, from the forwarding unit's Need_Stall.
REQ-006 branch_taken  in  1  taken branch/jump resolved in EX.
REQ-007 dmem_req  in  1  MA stage is issuing a data-memory access this cycle.
REQ-008 dmem_ready  in  1  data memory completes the access this cycle.
REQ-009 halt_req  in  1  debug halt request (level).
REQ-010 resume  in  1  debug resume pulse.
REQ-011 pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  pipeline register enables.
REQ-012 ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (NOP, R_WE=0, MemEnable=0).
REQ-013 halted  out  1  core halted.
REQ-014 bus_err  out  1  one-cycle pulse on DMEM timeout.
REQ-015 stall_cnt  out  STALL_CNT_W  saturating count of cycles with pc_we=0.

Function
REQ-016 SHALL implement an FSM with states RUN, DMEM_WAIT, HALTED; outputs are Mealy (current state + inputs).
REQ-017 Default in RUN: all *_we=1, all flushes=0.
REQ-018 RUN priority, highest first: (a) dmem_req&!dmem_ready, (b) branch_taken, (c) load_use, (d) halt_req.
REQ-019 RUN (a): all *_we=0, no flush; next DMEM_WAIT; wait counter cleared to 1.
REQ-020 RUN (b): all *_we=1, ifid_flush=1, idex_flush=1; load_use ignored this cycle; next RUN.
REQ-021 RUN (c): pc_we=ifid_we=idex_we=0, exmem_flush=1, memwb_we=1; next RUN (single bubble cycle).
REQ-022 RUN (d): all *_we=0; next HALTED.
REQ-023 DMEM_WAIT: all *_we=0 while dmem_ready=0; wait counter increments each cycle.
REQ-024 DMEM_WAIT with dmem_ready=1: outputs are evaluated as in RUN with (a) false, including branch and load-use handling; next state is per REQ-019..022, else RUN.
REQ-025 DMEM_WAIT with dmem_ready=0 and wait counter==TIMEOUT: bus_err=1 for exactly that cycle, all *_we=0; next HALTED.
REQ-026 HALTED: all *_we=0, no flush, halted=1; resume=1 -> next RUN (outputs still frozen that cycle); halt_req ignored while HALTED.
REQ-027 resume outside HALTED SHALL be ignored.
REQ-028 stall_cnt SHALL increment on every cycle with pc_we=0 and SHALL saturate at all-ones (no wrap).
REQ-029 A flush SHALL never coincide with the same register's we=0; flush implies that register loads the bubble.

Reset
REQ-030 rst=1 SHALL force state RUN, wait counter 0, stall_cnt 0, bus_err 0, halted 0 on the next edge, overriding all inputs, including mid-DMEM_WAIT.
REQ-031 While rst=1, outputs SHALL be: all *_we=1, all flushes=0, halted=0, bus_err=0.

Structure
REQ-032 The shared package pipe_ctrl_pkg SHALL hold the state enum (RUN=2'b00, DMEM_WAIT=2'b01, HALTED=2'b10) and the bubble-encoding constants.
REQ-033 SHALL instantiate one sub-module, sat_cnt (parameterised-width saturating counter with clear/inc), used for stall_cnt.

Verification
REQ-034 load_use=1 for 1 cycle in RUN -> that cycle pc_we=ifid_we=idex_we=0, exmem_flush=1; next cycle all we=1; stall_cnt=1.
REQ-035 branch_taken=1 and load_use=1 in the same cycle -> ifid_flush=idex_flush=1, pc_we=1, exmem_flush=0.
REQ-036 dmem_req=1, dmem_ready low for 3 cycles then high -> 3 frozen cycles, advance on the 4th, state RUN, stall_cnt=3.
REQ-037 TIMEOUT=4, dmem_ready never high -> bus_err pulses on the 4th DMEM_WAIT cycle, halted=1 next cycle; resume -> RUN.
REQ-038 rst asserted in the 2nd DMEM_WAIT cycle -> next cycle state RUN, stall_cnt=0, all we=1.
REQ-039 STALL_CNT_W=4 with 20 consecutive stall cycles -> stall_cnt holds 15.
